// File: rtl/rect_raster_engine.sv
// rtl/rect_raster_engine.sv - rectangle fill/blit rasteriser into the 640x480 RGB444 framebuffer
// Optional macro RRE_CLIP_EN: clamp bottom-right to the screen and skip empty rectangles.
module rect_raster_engine #(
    parameter int SCREEN_W    = 640,
    parameter int SCREEN_H    = 480,
    parameter int ROM_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        gp_en,
    input  logic        gp_opcode,
    input  logic [9:0]  gp_tl_x,
    input  logic [8:0]  gp_tl_y,
    input  logic [9:0]  gp_br_x,
    input  logic [8:0]  gp_br_y,
    input  logic [11:0] gp_arg,
    output logic        gp_finish,
    output logic        busy,
    output logic        vram_we,
    output logic [18:0] vram_addr,
    output logic [11:0] vram_data,
    output logic [19:0] rom_addr,
    input  logic [11:0] rom_data
);

    // Row-base arithmetic is a fixed shift-add for a 640 stride; one-cycle ROM only.
    if (ROM_LATENCY != 1 || SCREEN_W != 640 || SCREEN_H > 512) begin : g_bad_cfg
        $error("rect_raster_engine: unsupported configuration");
    end

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        RUN,
        FLUSH,
        DONE
    } state_t;

    state_t      state, state_next;

    logic        opcode_q;
    logic [9:0]  tl_x_q, br_x_q, x;
    logic [8:0]  tl_y_q, br_y_q, y;
    logic [11:0] arg_q;
    logic [18:0] row_base;
    logic [19:0] src;
    logic        blit_we_q;
    logic [18:0] blit_addr_q;
    logic        gp_finish_q;

    logic [18:0] pix_addr;
    logic        fill_we;
    logic        last_pix;
    logic [9:0]  br_x_c;
    logic [8:0]  br_y_c;
    logic        rect_empty;

`ifdef RRE_CLIP_EN
    always_comb begin
        br_x_c     = (br_x_q > 10'(SCREEN_W - 1)) ? 10'(SCREEN_W - 1) : br_x_q;
        br_y_c     = (br_y_q > 9'(SCREEN_H - 1)) ? 9'(SCREEN_H - 1) : br_y_q;
        rect_empty = (tl_x_q > br_x_c) || (tl_y_q > br_y_c);
    end
`else
    always_comb begin
        br_x_c     = br_x_q;
        br_y_c     = br_y_q;
        rect_empty = 1'b0;
    end
`endif

    assign pix_addr = row_base + {9'd0, x};
    assign last_pix = (x == br_x_q) && (y == br_y_q);
    assign fill_we  = (state == RUN) && !opcode_q;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (gp_en) state_next = SETUP;
            SETUP:   state_next = rect_empty ? DONE : RUN;
            RUN:     if (last_pix) state_next = opcode_q ? FLUSH : DONE;
            FLUSH:   state_next = DONE;
            DONE:    if (!gp_en) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            opcode_q    <= 1'b0;
            tl_x_q      <= '0;
            tl_y_q      <= '0;
            br_x_q      <= '0;
            br_y_q      <= '0;
            arg_q       <= '0;
            x           <= '0;
            y           <= '0;
            row_base    <= '0;
            src         <= '0;
            blit_we_q   <= 1'b0;
            blit_addr_q <= '0;
            gp_finish_q <= 1'b0;
        end else begin
            state       <= state_next;
            gp_finish_q <= (state_next == DONE);
            // Blit writes trail the ROM address by the ROM's one-cycle latency.
            blit_we_q   <= (state == RUN) && opcode_q;
            blit_addr_q <= pix_addr;
            case (state)
                IDLE: begin
                    if (gp_en) begin
                        opcode_q <= gp_opcode;
                        tl_x_q   <= gp_tl_x;
                        tl_y_q   <= gp_tl_y;
                        br_x_q   <= gp_br_x;
                        br_y_q   <= gp_br_y;
                        arg_q    <= gp_arg;
                    end
                end
                SETUP: begin
                    row_base <= ({10'd0, tl_y_q} << 9) + ({10'd0, tl_y_q} << 7);
                    x        <= tl_x_q;
                    y        <= tl_y_q;
                    src      <= {arg_q, 8'd0};
                    br_x_q   <= br_x_c;
                    br_y_q   <= br_y_c;
                end
                RUN: begin
                    src <= src + 20'd1;
                    if (x == br_x_q) begin
                        x        <= tl_x_q;
                        y        <= y + 9'd1;
                        row_base <= row_base + 19'(SCREEN_W);
                    end else begin
                        x <= x + 10'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        vram_we   = fill_we | blit_we_q;
        vram_addr = '0;
        vram_data = '0;
        if (blit_we_q) begin
            vram_addr = blit_addr_q;
            vram_data = rom_data;
        end else if (fill_we) begin
            vram_addr = pix_addr;
            vram_data = arg_q;
        end
    end

    assign rom_addr  = ((state == RUN) && opcode_q) ? src : 20'd0;
    assign busy      = (state != IDLE);
    assign gp_finish = gp_finish_q;

endmodule

// File: tb/tb_rect_raster_engine.sv
// tb/tb_rect_raster_engine.sv - directed bench for rect_raster_engine
module tb_rect_raster_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic        gp_en;
    logic        gp_opcode;
    logic [9:0]  gp_tl_x, gp_br_x;
    logic [8:0]  gp_tl_y, gp_br_y;
    logic [11:0] gp_arg;
    logic        gp_finish, busy, vram_we;
    logic [18:0] vram_addr;
    logic [11:0] vram_data;
    logic [19:0] rom_addr;
    logic [11:0] rom_data = '0;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    rect_raster_engine dut (
        .clk(clk), .rst(rst), .gp_en(gp_en), .gp_opcode(gp_opcode),
        .gp_tl_x(gp_tl_x), .gp_tl_y(gp_tl_y), .gp_br_x(gp_br_x), .gp_br_y(gp_br_y),
        .gp_arg(gp_arg), .gp_finish(gp_finish), .busy(busy), .vram_we(vram_we),
        .vram_addr(vram_addr), .vram_data(vram_data), .rom_addr(rom_addr), .rom_data(rom_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [11:0] rom_fn(input logic [19:0] a);
        return a[11:0] ^ a[19:8];
    endfunction

    always @(posedge clk) rom_data <= rom_fn(rom_addr);

    // Reference model of the expected write stream for the current command.
    int          c0 = 0, n_exp = 0;
    int          wr_cnt = 0, bad_wr = 0, first_addr = -1, last_addr = -1, first_rel = -1;
    int          rom_at2 = -1, rom_atn = -1;
    logic        m_op = 1'b0;
    logic [11:0] m_arg = '0;
    int          m_tlx = 0, m_brx = 0, ex = 0, ey = 0;

    always @(negedge clk) begin
        if (cyc - c0 == 2) rom_at2 = int'(rom_addr);
        if (cyc - c0 == n_exp + 1) rom_atn = int'(rom_addr);
        if (vram_we === 1'b1) begin
            if (wr_cnt == 0) begin
                first_addr = int'(vram_addr);
                first_rel  = cyc - c0;
            end
            last_addr = int'(vram_addr);
            if (int'(vram_addr) != ey * 640 + ex) bad_wr++;
            else if (vram_data !== (m_op ? rom_fn({m_arg, 8'd0} + 20'(wr_cnt)) : m_arg)) bad_wr++;
            wr_cnt++;
            if (ex == m_brx) begin
                ex = m_tlx;
                ey = ey + 1;
            end else begin
                ex = ex + 1;
            end
        end
    end

    task automatic check(input string tag, input longint obs, input longint exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic start(input logic op, input int tlx, input int tly, input int brx, input int bry,
                         input logic [11:0] arg);
        int cbx, cby;
        cbx = brx;
        cby = bry;
`ifdef RRE_CLIP_EN
        if (cbx > 639) cbx = 639;
        if (cby > 479) cby = 479;
`endif
        gp_opcode = op;
        gp_tl_x = 10'(tlx);
        gp_tl_y = 9'(tly);
        gp_br_x = 10'(brx);
        gp_br_y = 9'(bry);
        gp_arg = arg;
        gp_en = 1'b1;
        c0 = cyc;
        n_exp = (cbx >= tlx && cby >= tly) ? (cbx - tlx + 1) * (cby - tly + 1) : 0;
        m_op = op;
        m_arg = arg;
        m_tlx = tlx;
        m_brx = cbx;
        ex = tlx;
        ey = tly;
        wr_cnt = 0;
        bad_wr = 0;
        first_addr = -1;
        last_addr = -1;
        first_rel = -1;
        rom_at2 = -1;
        rom_atn = -1;
    endtask

    task automatic wait_fin(input int limit, output int rel);
        rel = -1;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (gp_finish === 1'b1) begin
                rel = cyc - c0;
                break;
            end
        end
    endtask

    int rel, saved;

    initial begin
        rst = 1'b1;
        gp_en = 1'b0;
        gp_opcode = 1'b0;
        gp_tl_x = '0;
        gp_tl_y = '0;
        gp_br_x = '0;
        gp_br_y = '0;
        gp_arg = '0;
        repeat (3) @(negedge clk);
        check("reset_vram_we", vram_we, 0);
        check("reset_gp_finish", gp_finish, 0);
        check("reset_busy", busy, 0);
        check("reset_vram_addr", vram_addr, 0);
        check("reset_rom_addr", rom_addr, 0);
        rst = 1'b0;
        @(negedge clk);

        // Fill ending at the bottom-right corner of the screen
        start(1'b0, 351, 400, 639, 479, 12'hFFF);
        wait_fin(30000, rel);
        check("fill_finish_cycle", rel, 23122);
        check("fill_writes", wr_cnt, 23120);
        check("fill_first_addr", first_addr, 256351);
        check("fill_last_addr", last_addr, 307199);
        check("fill_first_cycle", first_rel, 2);
        check("fill_stream", bad_wr, 0);
        gp_en = 1'b0;
        @(negedge clk);
        check("fill_idle_finish", gp_finish, 0);
        check("fill_idle_busy", busy, 0);

        // Blit from ROM page 5 (start 1280); rows wrap 350 -> 640
        start(1'b1, 0, 0, 350, 39, 12'h005);
        wait_fin(20000, rel);
        check("blit_finish_cycle", rel, 14043);
        check("blit_writes", wr_cnt, 14040);
        check("blit_first_addr", first_addr, 0);
        check("blit_last_addr", last_addr, 25310);
        check("blit_first_cycle", first_rel, 3);
        check("blit_stream", bad_wr, 0);
        check("blit_rom_first", rom_at2, 1280);
        check("blit_rom_last", rom_atn, 15319);
        gp_en = 1'b0;
        @(negedge clk);

        // Back-to-back fills with a one-cycle gp_en gap
        start(1'b0, 351, 150, 400, 164, 12'h0A5);
        wait_fin(2000, rel);
        check("b2b1_finish_cycle", rel, 752);
        check("b2b1_writes", wr_cnt, 750);
        check("b2b1_stream", bad_wr, 0);
        gp_en = 1'b0;
        @(negedge clk);
        check("b2b_gap_finish", gp_finish, 0);
        start(1'b0, 401, 234, 420, 248, 12'h5A0);
        wait_fin(2000, rel);
        check("b2b2_finish_cycle", rel, 302);
        check("b2b2_writes", wr_cnt, 300);
        check("b2b2_first_addr", first_addr, 150161);
        check("b2b2_first_cycle", first_rel, 2);
        check("b2b2_stream", bad_wr, 0);
        gp_en = 1'b0;
        @(negedge clk);

        // Single pixel
        start(1'b0, 10, 20, 10, 20, 12'hF9C);
        wait_fin(100, rel);
        check("pix_finish_cycle", rel, 3);
        check("pix_writes", wr_cnt, 1);
        check("pix_addr", first_addr, 12810);
        check("pix_stream", bad_wr, 0);
        gp_en = 1'b0;
        @(negedge clk);

        // Reset in cycle 100 of a full-screen fill
        start(1'b0, 0, 0, 639, 479, 12'h123);
        repeat (100) @(negedge clk);
        check("rst_pre_busy", busy, 1);
        check("rst_pre_we", vram_we, 1);
        rst = 1'b1;
        gp_en = 1'b0;
        @(negedge clk);
        check("rst_post_we", vram_we, 0);
        check("rst_post_finish", gp_finish, 0);
        check("rst_post_busy", busy, 0);
        check("rst_writes_before", wr_cnt, 99);
        saved = wr_cnt;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_no_writes_after", wr_cnt, saved);
        start(1'b0, 5, 5, 7, 6, 12'h0F0);
        wait_fin(100, rel);
        check("after_rst_finish_cycle", rel, 8);
        check("after_rst_writes", wr_cnt, 6);
        check("after_rst_first_addr", first_addr, 3205);
        check("after_rst_last_addr", last_addr, 3847);
        check("after_rst_stream", bad_wr, 0);
        gp_en = 1'b0;
        @(negedge clk);

`ifdef RRE_CLIP_EN
        start(1'b0, 600, 470, 700, 500, 12'h3C3);
        wait_fin(1000, rel);
        check("clip_writes", wr_cnt, 400);
        check("clip_last_addr", last_addr, 307199);
        check("clip_stream", bad_wr, 0);
        gp_en = 1'b0;
        @(negedge clk);
        start(1'b0, 650, 0, 660, 10, 12'h3C3);
        wait_fin(100, rel);
        check("clip_empty_finish_cycle", rel, 2);
        check("clip_empty_writes", wr_cnt, 0);
        gp_en = 1'b0;
        @(negedge clk);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
